// File: rtl/banked_sram_pkg.sv
// Shared types and address helpers for the banked SRAM controller.
package banked_sram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // Bank number from a word address (the bits just above the in-bank index).
  function automatic int unsigned bank_sel(input logic [31:0] addr,
                                           input int          iw,
                                           input int          num_banks);
    return (addr >> iw) & (num_banks - 1);
  endfunction

  // Word index inside a bank.
  function automatic int unsigned bank_index(input logic [31:0] addr,
                                             input int          depth);
    return addr & (depth - 1);
  endfunction

endpackage

// File: rtl/banked_sram_bank.sv
// Synchronous single-port memory bank with a registered read port.
module banked_sram_bank #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 128,
  localparam int IW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [IW-1:0]     i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: the array is deliberately left out of reset so it maps onto RAM; the clear sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  // Read register holds its value on idle and write cycles, keeping a stalled response stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_en && !i_we) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/banked_sram_ctrl.sv
// Banked word memory behind a valid/ready port with a post-reset clear sweep.
// Optional per-word parity is enabled by defining MEM_PARITY_EN.
module banked_sram_ctrl
  import banked_sram_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  int NUM_BANKS  = 2,
  parameter  int BANK_DEPTH = 128,
  localparam int DW         = 2 * WIDTH,
  localparam int AW         = $clog2(NUM_BANKS * BANK_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_perr,
  output logic          init_done
);

  localparam int IW  = $clog2(BANK_DEPTH);
  localparam int BW  = $clog2(NUM_BANKS);
  localparam int BSW = (BW > 0) ? BW : 1;
`ifdef MEM_PARITY_EN
  localparam int MW  = DW + 1;
`else
  localparam int MW  = DW;
`endif

  state_e               r_state;
  logic [IW-1:0]        r_clr_idx;
  logic                 r_init_done;
  logic                 r_rsp_valid;
  logic [BSW-1:0]       r_bank_sel;

  logic                 w_clearing;
  logic                 w_accept;
  logic                 w_rd_accept;
  logic [BSW-1:0]       w_req_bank;
  logic [IW-1:0]        w_req_idx;
  logic [IW-1:0]        w_mem_idx;
  logic                 w_mem_we;
  logic [MW-1:0]        w_req_wdata_mem;
  logic [MW-1:0]        w_mem_wdata;
  logic [NUM_BANKS-1:0] w_bank_en;
  logic [MW-1:0]        w_bank_rdata [NUM_BANKS];
  logic [MW-1:0]        w_rdata;

  assign w_clearing  = (r_state == CLEAR);
  assign req_ready   = (r_state == READY) && (!r_rsp_valid || rsp_ready);
  assign w_accept    = req_valid && req_ready;
  assign w_rd_accept = w_accept && !req_write;

  assign w_req_bank = BSW'(bank_sel(32'(req_addr), IW, NUM_BANKS));
  assign w_req_idx  = IW'(bank_index(32'(req_addr), BANK_DEPTH));

  // During the sweep every bank writes zero at the same index in parallel.
  assign w_mem_idx   = w_clearing ? r_clr_idx : w_req_idx;
  assign w_mem_we    = w_clearing || req_write;
  assign w_mem_wdata = w_clearing ? '0 : w_req_wdata_mem;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_bank_en = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bank_en[b] = w_clearing || (w_accept && (w_req_bank == BSW'(b)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= CLEAR;
      r_clr_idx   <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clr_idx <= r_clr_idx + IW'(1);
          if (r_clr_idx == IW'(BANK_DEPTH - 1)) begin
            r_state     <= READY;
            r_init_done <= 1'b1;
          end
        end
        READY: begin
          r_init_done <= 1'b1;
        end
      endcase
    end
  end

  // A new read reloads the response even in the cycle the old one is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_bank_sel  <= '0;
    end else if (w_rd_accept) begin
      r_rsp_valid <= 1'b1;
      r_bank_sel  <= w_req_bank;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : gen_bank
    banked_sram_bank #(
      .DATA_W (MW),
      .DEPTH  (BANK_DEPTH)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_bank_en[g]),
      .i_we    (w_mem_we),
      .i_idx   (w_mem_idx),
      .i_wdata (w_mem_wdata),
      .o_rdata (w_bank_rdata[g])
    );
  end

  always_comb begin
    w_rdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (r_bank_sel == BSW'(b)) begin
        w_rdata = w_bank_rdata[b];
      end
    end
  end

`ifdef MEM_PARITY_EN
  assign w_req_wdata_mem = {^req_wdata, req_wdata};
  assign rsp_rdata       = w_rdata[DW-1:0];
  assign rsp_perr        = r_rsp_valid && ((^w_rdata[DW-1:0]) != w_rdata[DW]);
`else
  assign w_req_wdata_mem = req_wdata;
  assign rsp_rdata       = w_rdata;
  assign rsp_perr        = 1'b0;
`endif

  assign rsp_valid = r_rsp_valid;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_banked_sram_ctrl.sv
// Scoreboard bench for banked_sram_ctrl: directed requests push expected read data,
// a monitor pops and compares every consumed response.
module tb_banked_sram_ctrl;

  localparam int WIDTH      = 8;
  localparam int NUM_BANKS  = 2;
  localparam int BANK_DEPTH = 128;
  localparam int DW         = 2 * WIDTH;
  localparam int AW         = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_ready = 1'b1;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_perr;
  logic          init_done;

  banked_sram_ctrl #(
    .WIDTH      (WIDTH),
    .NUM_BANKS  (NUM_BANKS),
    .BANK_DEPTH (BANK_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_perr  (rsp_perr),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          perr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares consumed responses and checks stability under back-pressure.
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid) begin
      if (stall_prev) check("rsp_hold", 32'(rsp_rdata), 32'(stall_data));
      if (!rsp_ready) check("req_ready_bp", 32'(req_ready), 0);
      if (rsp_ready) begin
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 0);
        end else begin
          e = sb_q.pop_front();
          check("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
          check("rsp_perr", 32'(rsp_perr), 32'(e.perr));
        end
      end
    end
    stall_prev = rst_n && rsp_valid && !rsp_ready;
    stall_data = rsp_rdata;
  end

  // Drive one request until accepted; reads push their expected response.
  task automatic do_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] exp_data, input logic exp_perr);
    logic acc;
    int   waited;
    acc = 1'b0;
    waited = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    while (!acc && waited < 100) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    req_valid = 1'b0;
    if (!acc) begin
      check("req_timeout", 32'(acc), 1);
    end else if (!wr) begin
      sb_q.push_back('{data: exp_data, perr: exp_perr});
      check("rd_latency", 32'(rsp_valid), 1);
    end
  endtask

  task automatic wait_init(input string name);
    int   count;
    logic early;
    count = 0;
    early = 1'b0;
    while (!init_done && count < 1000) begin
      @(posedge clk);
      #1;
      count++;
      if (!init_done && req_ready) early = 1'b1;
    end
    check(name, count, BANK_DEPTH);
    check("req_ready_pre_init", 32'(early), 0);
    check("req_ready_post_init", 32'(req_ready), 1);
  endtask

  initial begin
    // Reset state and clear duration
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 0);
    check("rst_rsp_perr", 32'(rsp_perr), 0);
    check("rst_init_done", 32'(init_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init_len");

    // Cleared words at bank boundaries
    do_req(1'b0, 8'h00, '0, 16'h0000, 1'b0);
    do_req(1'b0, 8'h7F, '0, 16'h0000, 1'b0);
    do_req(1'b0, 8'h80, '0, 16'h0000, 1'b0);
    do_req(1'b0, 8'hFF, '0, 16'h0000, 1'b0);

    // Same index in both banks must not alias
    do_req(1'b1, 8'h05, 16'h1234, '0, 1'b0);
    do_req(1'b1, 8'h85, 16'hABCD, '0, 1'b0);
    do_req(1'b0, 8'h05, '0, 16'h1234, 1'b0);
    do_req(1'b0, 8'h85, '0, 16'hABCD, 1'b0);

    // Write then immediate read of the same word
    do_req(1'b1, 8'h33, 16'hBEEF, '0, 1'b0);
    do_req(1'b0, 8'h33, '0, 16'hBEEF, 1'b0);

    // Back-to-back reads with a 2-cycle response stall
    do_req(1'b1, 8'h20, 16'h1111, '0, 1'b0);
    do_req(1'b1, 8'hA0, 16'h2222, '0, 1'b0);
    do_req(1'b1, 8'h21, 16'h3333, '0, 1'b0);
    do_req(1'b1, 8'hA1, 16'h4444, '0, 1'b0);
    fork
      begin
        do_req(1'b0, 8'h20, '0, 16'h1111, 1'b0);
        do_req(1'b0, 8'hA0, '0, 16'h2222, 1'b0);
        do_req(1'b0, 8'h21, '0, 16'h3333, 1'b0);
        do_req(1'b0, 8'hA1, '0, 16'h4444, 1'b0);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    check("bp_drained", sb_q.size(), 0);

`ifdef MEM_PARITY_EN
    // Corrupt one stored data bit and expect a parity error on that word only
    do_req(1'b1, 8'h10, 16'h00FF, '0, 1'b0);
    do_req(1'b1, 8'h11, 16'h0F0F, '0, 1'b0);
    dut.gen_bank[0].u_bank.r_mem[16][0] = ~dut.gen_bank[0].u_bank.r_mem[16][0];
    do_req(1'b0, 8'h10, '0, 16'h00FE, 1'b1);
    do_req(1'b0, 8'h11, '0, 16'h0F0F, 1'b0);
`endif

    // Reset during the sweep restarts it and wipes earlier writes
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midclr_init_done", 32'(init_done), 0);
    check("midclr_req_ready", 32'(req_ready), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init_len_restart");
    do_req(1'b0, 8'h05, '0, 16'h0000, 1'b0);
    do_req(1'b0, 8'h85, '0, 16'h0000, 1'b0);
    do_req(1'b0, 8'hA1, '0, 16'h0000, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
